regfile_sequencer: RTL and testbench

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

---
 rtl/regfile_sequencer.sv | 149 ++++++++++++++
 tb/tb_regfile_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// Decodes 16-bit instruction words into datapath controls. Done is 2 cycles after the last accepted word.
// In_Ready is high only in IDLE and IMM (low in IMM while Flush is high), so words are held off while an op is in flight.
module regfile_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [15:0]      In_Data,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic             Flush,
  input  logic [15:0]      RdestOut,
  input  logic [4:0]       Flags,
  output logic [3:0]       RdestLoc,
  output logic [3:0]       RsrcLoc,
  output logic [4:0]       OpCode,
  output logic [15:0]      Imm,
  output logic             Imm_s,
  output logic             En,
  output logic             RfRst,
  output logic [15:0]      Result,
  output logic [4:0]       Flags_q,
  output logic             Done,
  output logic             Busy,
  output logic [CNT_W-1:0] Retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IMM,
    S_EXEC,
    S_CLR,
    S_CAPT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_ready;
  logic             w_accept;
  logic             w_clr_op;
  logic             w_unused_bits;
  logic             r_from_clr;
  logic [3:0]       r_rdest;
  logic [3:0]       r_rsrc;
  logic [4:0]       r_opcode;
  logic [15:0]      r_imm;
  logic             r_imm_s;
  logic [15:0]      r_result;
  logic [4:0]       r_flags;
  logic [CNT_W-1:0] r_retired;

  // Flush wins over a same-cycle accept in IMM, so the word is never taken.
  assign w_ready       = (r_state == S_IDLE) || ((r_state == S_IMM) && !Flush);
  assign w_accept      = In_Valid && w_ready;
  assign w_clr_op      = (In_Data[15:11] == 5'b11111);
  assign w_unused_bits = ^In_Data[1:0];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    En     = 1'b0;
    RfRst  = 1'b0;
    Done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_clr_op)        w_next = S_CLR;
          else if (In_Data[10]) w_next = S_IMM;
          else                  w_next = S_EXEC;
        end
      end
      S_IMM: begin
        if (Flush)         w_next = S_IDLE;
        else if (w_accept) w_next = S_EXEC;
      end
      S_EXEC: begin
        En     = 1'b1;
        w_next = S_CAPT;
      end
      S_CLR: begin
        RfRst  = 1'b1;
        w_next = S_CAPT;
      end
      S_CAPT: begin
        Done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_from_clr <= 1'b0;
      r_rdest    <= '0;
      r_rsrc     <= '0;
      r_opcode   <= '0;
      r_imm      <= '0;
      r_imm_s    <= 1'b0;
      r_result   <= '0;
      r_flags    <= '0;
      r_retired  <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_accept) begin
        r_from_clr <= w_clr_op;
        if (!w_clr_op) begin
          r_opcode <= In_Data[15:11];
          r_imm_s  <= In_Data[10];
          r_rdest  <= In_Data[9:6];
          r_rsrc   <= In_Data[5:2];
          if (!In_Data[10]) r_imm <= '0;
        end
      end
      if ((r_state == S_IMM) && w_accept) begin
        r_imm <= In_Data;
      end
      // A clear completes like an instruction but does not count as retired.
      if (r_state == S_CAPT) begin
        if (r_from_clr) begin
          r_result <= '0;
          r_flags  <= '0;
        end else begin
          r_result  <= RdestOut;
          r_flags   <= Flags;
          r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign In_Ready = w_ready;
  assign Busy     = (r_state != S_IDLE);
  assign RdestLoc = r_rdest;
  assign RsrcLoc  = r_rsrc;
  assign OpCode   = r_opcode;
  assign Imm      = r_imm;
  assign Imm_s    = r_imm_s;
  assign Result   = r_result;
  assign Flags_q  = r_flags;
  assign Retired  = r_retired;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: vector table plus scoreboard of expected datapath fields and captured results.
module tb_regfile_sequencer;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [15:0] In_Data = '0;
  logic        In_Valid = 1'b0;
  logic        In_Ready;
  logic        Flush = 1'b0;
  logic [15:0] RdestOut = '0;
  logic [4:0]  Flags = '0;
  logic [3:0]  RdestLoc, RsrcLoc;
  logic [4:0]  OpCode;
  logic [15:0] Imm;
  logic        Imm_s, En, RfRst, Done, Busy;
  logic [15:0] Result;
  logic [4:0]  Flags_q;
  logic [7:0]  Retired;

  regfile_sequencer #(.CNT_W(8)) dut (
    .Clk(Clk), .Rst(Rst), .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Flush(Flush), .RdestOut(RdestOut), .Flags(Flags), .RdestLoc(RdestLoc), .RsrcLoc(RsrcLoc),
    .OpCode(OpCode), .Imm(Imm), .Imm_s(Imm_s), .En(En), .RfRst(RfRst), .Result(Result),
    .Flags_q(Flags_q), .Done(Done), .Busy(Busy), .Retired(Retired)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] word;
    logic        has_imm;
    logic [15:0] imm;
    logic [15:0] rout;
    logic [4:0]  fl;
    logic        is_clr;
    logic [4:0]  op;
    logic        ims;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] e_imm;
    logic [15:0] e_res;
    logic [4:0]  e_fl;
  } vec_t;

  typedef struct {
    logic [4:0]  op;
    logic        ims;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] imm;
    logic [15:0] res;
    logic [4:0]  fl;
    logic        is_clr;
  } exp_t;

  int   n_tests = 0;
  int   n_fail = 0;
  int   en_cnt = 0;
  int   rf_cnt = 0;
  int   done_cnt = 0;
  logic capt_pend = 1'b0;
  logic [7:0] model_ret = '0;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard side: fields checked on every En, results one cycle after Done.
  always @(negedge Clk) begin
    if (!Rst) begin
      exp_q.delete();
      capt_pend = 1'b0;
      model_ret = '0;
    end else begin
      if (En) en_cnt++;
      if (RfRst) rf_cnt++;
      if (Done) done_cnt++;
      if (En && RfRst) check("en_rfrst_overlap", {31'b0, RfRst}, 32'd0);
      if (capt_pend) begin
        mon_e = exp_q.pop_front();
        if (!mon_e.is_clr) model_ret++;
        check("result", {16'b0, Result}, {16'b0, mon_e.res});
        check("flags_q", {27'b0, Flags_q}, {27'b0, mon_e.fl});
        check("retired", {24'b0, Retired}, {24'b0, model_ret});
        capt_pend = 1'b0;
      end
      if (En) begin
        if (exp_q.size() == 0) check("unexpected_en", {31'b0, En}, 32'd0);
        else begin
          check("opcode", {27'b0, OpCode}, {27'b0, exp_q[0].op});
          check("imm_s", {31'b0, Imm_s}, {31'b0, exp_q[0].ims});
          check("rdest", {28'b0, RdestLoc}, {28'b0, exp_q[0].rd});
          check("rsrc", {28'b0, RsrcLoc}, {28'b0, exp_q[0].rs});
          check("imm", {16'b0, Imm}, {16'b0, exp_q[0].imm});
        end
      end
      if (Done) begin
        if (exp_q.size() == 0) check("unexpected_done", {31'b0, Done}, 32'd0);
        else capt_pend = 1'b1;
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input logic [15:0] d);
    int g;
    In_Data  = d;
    In_Valid = 1'b1;
    g = 0;
    while (!In_Ready && g < 50) begin
      @(negedge Clk);
      g++;
    end
    if (g >= 50) check("ready_wait", {31'b0, In_Ready}, 32'd1);
    @(posedge Clk);
    @(negedge Clk);
    In_Valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   lat;
    e = '{v.op, v.ims, v.rd, v.rs, v.e_imm, v.e_res, v.e_fl, v.is_clr};
    exp_q.push_back(e);
    RdestOut = v.rout;
    Flags    = v.fl;
    en_cnt   = 0;
    rf_cnt   = 0;
    send(v.word);
    if (v.has_imm) send(v.imm);
    check("en_after_accept", {31'b0, En}, {31'b0, ~v.is_clr});
    lat = 1;
    while (!Done && lat < 20) begin
      @(negedge Clk);
      lat++;
    end
    check("done_latency", lat, 32'd2);
    @(negedge Clk);
    check("done_one_cycle", {31'b0, Done}, 32'd0);
    check("busy_after", {31'b0, Busy}, 32'd0);
    check("en_count", en_cnt, v.is_clr ? 32'd0 : 32'd1);
    check("rfrst_count", rf_cnt, v.is_clr ? 32'd1 : 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h0A54, 1'b0, 16'h0000, 16'h1234, 5'h02, 1'b0, 5'd1,  1'b0, 4'd9,  4'd5,  16'h0000, 16'h1234, 5'h02};
    vecs[1] = '{16'h0C40, 1'b1, 16'hBEEF, 16'h5555, 5'h1F, 1'b0, 5'd1,  1'b1, 4'd1,  4'd0,  16'hBEEF, 16'h5555, 5'h1F};
    vecs[2] = '{16'hF800, 1'b0, 16'h0000, 16'hAAAA, 5'h15, 1'b1, 5'd0,  1'b0, 4'd0,  4'd0,  16'h0000, 16'h0000, 5'h00};
    vecs[3] = '{16'hB3CF, 1'b0, 16'h0000, 16'hFFFF, 5'h10, 1'b0, 5'd22, 1'b0, 4'd15, 4'd3,  16'h0000, 16'hFFFF, 5'h10};
    vecs[4] = '{16'hF43D, 1'b1, 16'h8001, 16'h0001, 5'h01, 1'b0, 5'd30, 1'b1, 4'd0,  4'd15, 16'h8001, 16'h0001, 5'h01};
    vecs[5] = '{16'hFC00, 1'b0, 16'h0000, 16'h7777, 5'h07, 1'b1, 5'd0,  1'b0, 4'd0,  4'd0,  16'h0000, 16'h0000, 5'h00};
    vecs[6] = '{16'h01A8, 1'b0, 16'h0000, 16'h0000, 5'h00, 1'b0, 5'd0,  1'b0, 4'd6,  4'd10, 16'h0000, 16'h0000, 5'h00};

    // Reset state
    repeat (2) @(negedge Clk);
    check("rst_in_ready", {31'b0, In_Ready}, 32'd1);
    check("rst_busy", {31'b0, Busy}, 32'd0);
    check("rst_en_rfrst_done", {29'b0, En, RfRst, Done}, 32'd0);
    check("rst_result", {16'b0, Result}, 32'd0);
    check("rst_retired", {24'b0, Retired}, 32'd0);
    check("rst_fields", {OpCode, Imm_s, RdestLoc, RsrcLoc, Imm}, 44'd0);
    Rst = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Fields must hold across a clear.
    run_vec(vecs[1]);
    run_vec(vecs[2]);
    check("hold_opcode", {27'b0, OpCode}, 32'd1);
    check("hold_imm", {16'b0, Imm}, 32'h0000BEEF);
    check("hold_rdest", {28'b0, RdestLoc}, 32'd1);

    // Flush in IMM beats a same-cycle valid word.
    en_cnt = 0;
    done_cnt = 0;
    send(16'h0C40);
    check("imm_state_busy", {31'b0, Busy}, 32'd1);
    In_Data  = 16'h1234;
    In_Valid = 1'b1;
    Flush    = 1'b1;
    @(negedge Clk);
    In_Valid = 1'b0;
    Flush    = 1'b0;
    check("flush_idle", {31'b0, Busy}, 32'd0);
    repeat (4) @(negedge Clk);
    check("flush_no_en", en_cnt, 32'd0);
    check("flush_no_done", done_cnt, 32'd0);
    run_vec(vecs[0]);

    // Flush held high outside IMM has no effect.
    Flush = 1'b1;
    run_vec(vecs[3]);
    Flush = 1'b0;

    // Reset while in IMM, then the wrap run from a clean counter.
    send(16'h0C40);
    Rst = 1'b0;
    #1;
    check("rst_imm_busy", {31'b0, Busy}, 32'd0);
    check("rst_imm_ready", {31'b0, In_Ready}, 32'd1);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    for (int i = 0; i < 256; i++) begin
      vec_t v;
      logic [15:0] res;
      res = 16'(i * 3);
      v = '{{5'd2, 1'b0, 4'(i), ~4'(i), 2'b00}, 1'b0, 16'h0, res, 5'(i), 1'b0,
            5'd2, 1'b0, 4'(i), ~4'(i), 16'h0, res, 5'(i)};
      run_vec(v);
    end
    check("retired_wrapped", {24'b0, Retired}, 32'd0);

    // Reset during EXEC discards the instruction.
    RdestOut = 16'hCAFE;
    Flags    = 5'h0C;
    exp_q.push_back('{5'd1, 1'b0, 4'd9, 4'd5, 16'h0, 16'hCAFE, 5'h0C, 1'b0});
    send(16'h0A54);
    check("exec_en", {31'b0, En}, 32'd1);
    Rst = 1'b0;
    #1;
    check("rst_exec_en", {31'b0, En}, 32'd0);
    check("rst_exec_outs", {Busy, RfRst, Done, Result, Flags_q, Retired}, 32'd0);
    check("rst_exec_fields", {OpCode, Imm_s, RdestLoc, RsrcLoc, Imm}, 44'd0);
    @(negedge Clk);
    Rst = 1'b1;
    done_cnt = 0;
    repeat (5) @(negedge Clk);
    check("rst_exec_no_done", done_cnt, 32'd0);
    check("rst_exec_result", {16'b0, Result}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
